// File: rtl/ariane_pkg.sv
// Slice of the core-wide package holding the AMO request/response types
// shared by the load/store units, the data cache and the AMO port arbiter.
package ariane_pkg;

   typedef enum logic [3:0] {
      AMO_NONE = 4'b0000,
      AMO_LR   = 4'b0001,
      AMO_SC   = 4'b0010,
      AMO_SWAP = 4'b0011,
      AMO_ADD  = 4'b0100,
      AMO_AND  = 4'b0101,
      AMO_OR   = 4'b0110,
      AMO_XOR  = 4'b0111,
      AMO_MAX  = 4'b1000,
      AMO_MAXU = 4'b1001,
      AMO_MIN  = 4'b1010,
      AMO_MINU = 4'b1011,
      AMO_CAS1 = 4'b1100,
      AMO_CAS2 = 4'b1101
   } amo_t;

   typedef struct packed {
      logic        req;
      amo_t        amo_op;
      logic [1:0]  size;
      logic [63:0] operand_a;
      logic [63:0] operand_b;
   } amo_req_t;

   typedef struct packed {
      logic        ack;
      logic [63:0] result;
   } amo_resp_t;

endpackage

// File: rtl/amo_rr_picker.sv
// Combinational round-robin picker: returns the first asserted request at or
// after rr_ptr, wrapping modulo NrPorts.
module amo_rr_picker #(
   parameter int unsigned NrPorts = 2,
   parameter int unsigned IdxW    = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
   input  logic [NrPorts-1:0] req,
   input  logic [IdxW-1:0]    rr_ptr,
   output logic               valid,
   output logic [IdxW-1:0]    idx
);

   logic [IdxW-1:0] cand;
   int unsigned     pos;

   // Walk the ports in priority order p, p+1, ..., p-1 and keep the first hit.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      pos   = 0;
      for (int unsigned i = 0; i < NrPorts; i++) begin
         pos = 32'(rr_ptr) + i;
         if (pos >= NrPorts) pos = pos - NrPorts;
         cand = IdxW'(pos);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/amo_port_arbiter.sv
// Shares the single D$ AMO port between NrPorts requesters with a round-robin
// grant that is held (and its request latched) until the cache acknowledges.
module amo_port_arbiter
   import ariane_pkg::*;
#(
   parameter  int unsigned NrPorts = 2,
   localparam int unsigned IdxW    = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  amo_req_t  [NrPorts-1:0]   amo_req_i,
   output amo_resp_t [NrPorts-1:0]   amo_resp_o,
   output amo_req_t                  amo_req_o,
   input  amo_resp_t                 amo_resp_i,
   output logic                      busy_o,
   output logic [IdxW-1:0]           gnt_idx_o
);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t             state;
   logic [IdxW-1:0]    rr_ptr;
   logic [IdxW-1:0]    gnt_idx;
   amo_req_t           req_q;
   amo_req_t           pick_req;
   logic [NrPorts-1:0] req_vec;
   logic [NrPorts-1:0] ack_vec;
   logic               pick_valid;
   logic [IdxW-1:0]    pick_idx;

   always_comb begin
      for (int k = 0; k < NrPorts; k++) begin
         req_vec[k] = amo_req_i[k].req;
      end
   end

   amo_rr_picker #(
      .NrPorts (NrPorts),
      .IdxW    (IdxW)
   ) u_picker (
      .req    (req_vec),
      .rr_ptr (rr_ptr),
      .valid  (pick_valid),
      .idx    (pick_idx)
   );

   always_comb begin
      pick_req     = amo_req_i[pick_idx];
      pick_req.req = 1'b1;
   end

   // The latched request is cleared on ack so amo_req_o reads all-zero in IDLE.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         gnt_idx <= '0;
         req_q   <= '0;
         busy_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  req_q   <= pick_req;
                  gnt_idx <= pick_idx;
                  busy_o  <= 1'b1;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (amo_resp_i.ack) begin
                  req_q  <= '0;
                  busy_o <= 1'b0;
                  state  <= IDLE;
                  rr_ptr <= (gnt_idx == IdxW'(NrPorts - 1)) ? '0 : gnt_idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign amo_req_o = req_q;
   assign gnt_idx_o = gnt_idx;

   // Only the granted port sees the cache response, and only while BUSY.
   always_comb begin
      for (int k = 0; k < NrPorts; k++) begin
         amo_resp_o[k] = '0;
         ack_vec[k]    = 1'b0;
         if (state == BUSY && amo_resp_i.ack && gnt_idx == IdxW'(k)) begin
            amo_resp_o[k] = amo_resp_i;
            ack_vec[k]    = 1'b1;
         end
      end
   end

`ifndef SYNTHESIS
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(state == IDLE && amo_resp_i.ack))
      else $warning("amo_port_arbiter: spurious ack received while idle");

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state == BUSY && !amo_resp_i.ack) |=> $stable(amo_req_o));

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(ack_vec));
`endif

endmodule
